return_addr_stack: RTL and testbench
====================================

Name: return_addr_stack

Overview:
- Hardware return-address stack for mycpu. It produces the return address that the program counter selects on a return.
- On a call it captures the PC-relative return address. On a return it pops that address.
- Its top-of-stack output feeds the PC block's return-address input.
- It sits beside the PC, driven by decode: `push_in` on CALL, `pop_in` on RET.

Parameters:
- DEPTH, 8, number of stack entries (power of two, 2..64).
- AW, 16, address width; must match the PC width.

Ports:
- clk       in   1      system clock, rising-edge.
- rst       in   1      asynchronous, active-high reset.
- push_in   in   1      CALL executing this cycle; push return address.
- pop_in    in   1      RET executing this cycle; pop top entry.
- pc_in     in   AW     current PC value (address of the CALL instruction).
- ra_out    out  AW     top-of-stack return address (to PC return-address input).
- empty_out out  1      stack holds 0 entries.
- full_out  out  1      stack holds DEPTH entries.
- ovf_out   out  1      sticky: push attempted while full.
- udf_out   out  1      sticky: pop attempted while empty.

Behaviour:
- Storage: DEPTH x AW register array. Pointer `sp` is $clog2(DEPTH) bits. Occupancy `cnt` is $clog2(DEPTH)+1 bits, 0..DEPTH.
- Reset (async assert, sync release on clk):
  - `cnt`=0, `sp`=0, all entries cleared to 0.
  - `ra_out`=0, `empty_out`=1, `full_out`=0, `ovf_out`=0, `udf_out`=0.
- Pushed value: `pc_in + 1`, truncated to AW bits. 16'hFFFF + 1 wraps to 16'h0000.
- Outputs are combinational from registered state only; no input-to-output path.
  - `ra_out` = entry[sp-1] when `cnt`>0, else 0.
  - `empty_out` = (`cnt`==0); `full_out` = (`cnt`==DEPTH).
- Latency: a push or pop at edge N is visible on `ra_out` and the flags after edge N. A RET following a CALL on the next cycle sees the new return address.
- Operation per rising edge, priority in listed order:
  - `push_in` & `pop_in` & `cnt`>0: replace top entry with the pushed value; `cnt` and `sp` unchanged.
  - `push_in` & `pop_in` & `cnt`==0: behaves as push only; `udf_out` not set.
  - `push_in` only, `cnt`<DEPTH: write entry[sp], `sp`+1, `cnt`+1.
  - `push_in` only, `cnt`==DEPTH: push dropped, state unchanged, `ovf_out`<=1. Default build; see Optional Feature.
  - `pop_in` only, `cnt`>0: `sp`-1, `cnt`-1. The vacated entry is not cleared.
  - `pop_in` only, `cnt`==0: no state change, `udf_out`<=1, `ra_out` stays 0.
  - Neither asserted: hold.
- Sticky flags clear only on `rst`.
- Reset asserted mid-operation: every register returns to its reset value immediately; in-flight push/pop lost.
- X on `push_in`/`pop_in` outside reset is a protocol violation (SVA in the bind file).

Optional Feature:
- Macro: `RAS_WRAP_EN`.
- Defined: the stack is circular.
  - A push while full overwrites the oldest entry: write entry[sp], `sp` wraps modulo DEPTH, `cnt` stays DEPTH.
  - `ovf_out` is still set, marking loss of the oldest frame.
  - Deep recursion keeps the most recent DEPTH return addresses.
- Not defined: a push while full is dropped and the stack is unchanged (Behaviour above). `sp` never wraps; this is asserted.

Test Plan:
- Reset, then idle 3 cycles -> `ra_out`=0, `empty_out`=1, `full_out`=0, `ovf_out`=0, `udf_out`=0.
- Push with `pc_in`=16'h0010, then push with 16'h0200, then pop twice:
  - after the pushes, `ra_out`=16'h0011 then 16'h0201;
  - after the first pop, `ra_out`=16'h0011;
  - after the second pop, `ra_out`=0 and `empty_out`=1.
- Push 8 times with `pc_in`=16'h0100..16'h0107, then a 9th push with 16'h0300:
  - `full_out`=1 after the 8th push; the 9th sets `ovf_out`=1.
  - Without `RAS_WRAP_EN`: `ra_out`=16'h0108 and 8 pops return 0x0108..0x0101.
  - With `RAS_WRAP_EN`: `ra_out`=16'h0301 and 8 pops return 0x0301, then 0x0108..0x0102.
- Pop while empty -> `udf_out`=1 and stays 1; `ra_out`=0; the next push with 16'h0040 gives `ra_out`=16'h0041.
- Push 16'h0020, then push+pop in the same cycle with 16'h0050 -> `ra_out`=16'h0051, `cnt` still 1, and one pop gives `empty_out`=1.
- Push with `pc_in`=16'hFFFF -> `ra_out`=16'h0000 and `empty_out`=0. Then push 3 entries and assert `rst` between edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return-address stack: CALL pushes pc_in+1, RET pops; top entry drives ra_out. Optional macro RAS_WRAP_EN makes it circular.
// Latency: push/pop at edge N is visible on ra_out and flags after edge N; outputs depend on registered state only.
// Backpressure: none; a push while full is dropped (or overwrites the oldest entry) and pop while empty is ignored, both flagged sticky.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_in,
    input  logic          pop_in,
    input  logic [AW-1:0] pc_in,
    output logic [AW-1:0] ra_out,
    output logic          empty_out,
    output logic          full_out,
    output logic          ovf_out,
    output logic          udf_out
);
    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = SPW + 1;

    logic [AW-1:0]  r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_cnt;
    logic           r_ovf;
    logic           r_udf;

    logic [AW-1:0]  w_push_val;
    logic [SPW-1:0] w_top_idx;
    logic           w_empty;
    logic           w_full;

    assign w_push_val = pc_in + AW'(1);
    // sp is DEPTH-modular, so sp-1 also addresses the top of a full stack
    assign w_top_idx  = r_sp - SPW'(1);
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CW'(DEPTH));

    assign ra_out    = w_empty ? '0 : r_mem[w_top_idx];
    assign empty_out = w_empty;
    assign full_out  = w_full;
    assign ovf_out   = r_ovf;
    assign udf_out   = r_udf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_sp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (push_in && pop_in && !w_empty) begin
            r_mem[w_top_idx] <= w_push_val;
        end else if (push_in) begin
            if (!w_full) begin
                r_mem[r_sp] <= w_push_val;
                r_sp        <= r_sp + SPW'(1);
                r_cnt       <= r_cnt + CW'(1);
            end else begin
                r_ovf <= 1'b1;
`ifdef RAS_WRAP_EN
                r_mem[r_sp] <= w_push_val;
                r_sp        <= r_sp + SPW'(1);
`endif
            end
        end else if (pop_in) begin
            if (!w_empty) begin
                r_sp  <= r_sp - SPW'(1);
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_udf <= 1'b1;
            end
        end
    end

    a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({push_in, pop_in}));

`ifndef RAS_WRAP_EN
    // without wrap, sp always equals occupancy modulo DEPTH
    a_sp_no_wrap: assert property (@(posedge clk) disable iff (rst)
        r_sp == r_cnt[SPW-1:0]);
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: directed scenarios plus random traffic against a queue-based model.
module tb_return_addr_stack;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_in = 1'b0;
    logic        pop_in = 1'b0;
    logic [15:0] pc_in = '0;
    logic [15:0] ra_out;
    logic        empty_out, full_out, ovf_out, udf_out;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_q[$];
    logic        m_ovf, m_udf;

    always #5 clk = ~clk;

    return_addr_stack #(.DEPTH(DEPTH), .AW(16)) dut (
        .clk(clk), .rst(rst), .push_in(push_in), .pop_in(pop_in), .pc_in(pc_in),
        .ra_out(ra_out), .empty_out(empty_out), .full_out(full_out),
        .ovf_out(ovf_out), .udf_out(udf_out)
    );

    wire [19:0] dut_vec = {ra_out, empty_out, full_out, ovf_out, udf_out};

    function automatic logic [19:0] exp_vec();
        logic [15:0] ra;
        ra = (m_q.size() > 0) ? m_q[m_q.size()-1] : 16'h0000;
        return {ra, m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_udf};
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Apply one cycle of stimulus, update the model, then sample #1 after the edge.
    task automatic step(input logic push, input logic pop, input logic [15:0] pc);
        logic [15:0] v;
        push_in = push;
        pop_in  = pop;
        pc_in   = pc;
        v = pc + 16'd1;
        if (push && pop && m_q.size() > 0) begin
            m_q[m_q.size()-1] = v;
        end else if (push) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(v);
            end else begin
                m_ovf = 1'b1;
`ifdef RAS_WRAP_EN
                void'(m_q.pop_front());
                m_q.push_back(v);
`endif
            end
        end else if (pop) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_udf = 1'b1;
        end
        @(posedge clk);
        #1;
        push_in = 1'b0;
        pop_in  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step(1'b0, 1'b0, 16'h1234);
        checks++;
        if (dut_vec !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_idle got=%h want=%h", dut_vec, {16'h0000, 4'b1000});
        end
    endtask

    task automatic test_push_pop();
        logic [15:0] want [4] = '{16'h0011, 16'h0201, 16'h0011, 16'h0000};
        do_reset();
        step(1'b1, 1'b0, 16'h0010);
        checks++;
        if (ra_out !== want[0]) begin failures++; $display("FAIL pp_push1 got=%h want=%h", ra_out, want[0]); end
        step(1'b1, 1'b0, 16'h0200);
        checks++;
        if (ra_out !== want[1]) begin failures++; $display("FAIL pp_push2 got=%h want=%h", ra_out, want[1]); end
        step(1'b0, 1'b1, 16'h0000);
        checks++;
        if (ra_out !== want[2]) begin failures++; $display("FAIL pp_pop1 got=%h want=%h", ra_out, want[2]); end
        step(1'b0, 1'b1, 16'h0000);
        checks++;
        if ({ra_out, empty_out} !== {want[3], 1'b1}) begin
            failures++; $display("FAIL pp_pop2 got=%h/%b want=%h/1", ra_out, empty_out, want[3]);
        end
    endtask

    task automatic test_fill_overflow();
        logic [15:0] exp_ra;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i));
        checks++;
        if ({full_out, ovf_out, ra_out} !== {1'b1, 1'b0, 16'h0108}) begin
            failures++; $display("FAIL fill_full got=%b%b/%h want=10/0108", full_out, ovf_out, ra_out);
        end
        step(1'b1, 1'b0, 16'h0300);
`ifdef RAS_WRAP_EN
        exp_ra = 16'h0301;
`else
        exp_ra = 16'h0108;
`endif
        checks++;
        if ({ovf_out, full_out, ra_out} !== {1'b1, 1'b1, exp_ra}) begin
            failures++; $display("FAIL ovf_push got=%b%b/%h want=11/%h", ovf_out, full_out, ra_out, exp_ra);
        end
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RAS_WRAP_EN
            exp_ra = (i == 0) ? 16'h0301 : 16'h0108 - 16'(i - 1);
`else
            exp_ra = 16'h0108 - 16'(i);
`endif
            checks++;
            if (ra_out !== exp_ra) begin
                failures++; $display("FAIL ovf_pop%0d got=%h want=%h", i, ra_out, exp_ra);
            end
            step(1'b0, 1'b1, 16'h0000);
        end
        checks++;
        if (dut_vec !== exp_vec() || empty_out !== 1'b1) begin
            failures++; $display("FAIL ovf_drained got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 1'b1, 16'h0000);
        checks++;
        if ({udf_out, ra_out, empty_out} !== {1'b1, 16'h0000, 1'b1}) begin
            failures++; $display("FAIL udf_set got=%b/%h/%b want=1/0000/1", udf_out, ra_out, empty_out);
        end
        step(1'b1, 1'b0, 16'h0040);
        checks++;
        if ({udf_out, ra_out} !== {1'b1, 16'h0041}) begin
            failures++; $display("FAIL udf_sticky got=%b/%h want=1/0041", udf_out, ra_out);
        end
    endtask

    task automatic test_push_pop_same();
        do_reset();
        step(1'b1, 1'b1, 16'h0007);
        checks++;
        if ({ra_out, empty_out, udf_out} !== {16'h0008, 1'b0, 1'b0}) begin
            failures++; $display("FAIL pushpop_empty got=%h/%b/%b want=0008/0/0", ra_out, empty_out, udf_out);
        end
        step(1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 16'h0020);
        step(1'b1, 1'b1, 16'h0050);
        checks++;
        if ({ra_out, empty_out} !== {16'h0051, 1'b0}) begin
            failures++; $display("FAIL pushpop_replace got=%h/%b want=0051/0", ra_out, empty_out);
        end
        step(1'b0, 1'b1, 16'h0000);
        checks++;
        if ({empty_out, ra_out} !== {1'b1, 16'h0000}) begin
            failures++; $display("FAIL pushpop_cnt got=%b/%h want=1/0000", empty_out, ra_out);
        end
    endtask

    task automatic test_pc_wrap_and_reset();
        do_reset();
        step(1'b1, 1'b0, 16'hFFFF);
        checks++;
        if ({ra_out, empty_out} !== {16'h0000, 1'b0}) begin
            failures++; $display("FAIL pc_wrap got=%h/%b want=0000/0", ra_out, empty_out);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0A00 + 16'(i));
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 16'h0B00);
        step(1'b1, 1'b0, 16'h0B01);
        step(1'b1, 1'b0, 16'h0B02);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== {16'h0000, 4'b1000}) begin
            failures++; $display("FAIL async_reset got=%h want=%h", dut_vec, {16'h0000, 4'b1000});
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(1'b0, 1'b0, 16'h0000);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL post_reset got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int errs;
        logic p, q;
        do_reset();
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            step(p, q, 16'($urandom));
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                errs++;
                if (errs <= 5) $display("FAIL rand_%0d got=%h want=%h", n, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_underflow();
        test_push_pop_same();
        test_pc_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
